// File: rtl/cpu_sequencer_if.sv
// Shared memory port between the sequencer (master) and the memory (slave).
//   mem_req      : request, held until mem_ack
//   mem_we       : write strobe, qualified by mem_req
//   mem_addr_sel : address source, 0 = PC, 1 = ALU result
//   mem_ack      : single-cycle completion pulse from memory
interface cpu_sequencer_if;
   logic mem_req;
   logic mem_we;
   logic mem_addr_sel;
   logic mem_ack;

   modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ack);
   modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ack);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode, execute,
// memory and writeback over a single shared req/ack memory port.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start, stop     : leave IDLE / return to IDLE at next instruction boundary
//   ir_op           : instruction class (00 mem, 01 ALU, 10 jump, 11 reserved)
//   dec_mem_write   : store flag from decoder
//   dec_cmp_ctrl    : comparator control from decoder
//   branch_taken    : comparator result, valid in EXEC
//   mem             : memory handshake interface (master side)
//   ir_write, pc_inc, pc_load, reg_write_en : datapath strobes (combinational)
//   busy, fault, state                      : status / debug
//   perf_cycles, perf_instrs                : performance counters
// Optional feature: define SEQ_PERF_CNT_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module cpu_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned TO_W        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic [1:0]            ir_op,
   input  logic                  dec_mem_write,
   input  logic [2:0]            dec_cmp_ctrl,
   input  logic                  branch_taken,
   cpu_sequencer_if.master       mem,
   output logic                  ir_write,
   output logic                  pc_inc,
   output logic                  pc_load,
   output logic                  reg_write_en,
   output logic                  busy,
   output logic                  fault,
   output logic [2:0]            state,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           perf_instrs
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   // Last counter value before the limit: the wait cycle that sees it is the final one.
   localparam int unsigned TO_LAST_I = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LAST_I);
   localparam bit TO_EN = (MEM_TIMEOUT != 0);

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            boundary_c;
   logic            to_expired_c;
   logic            mem_req_c, mem_we_c, mem_addr_sel_c;

   assign to_expired_c = TO_EN && (to_cnt_q == TO_LAST);

   // State and timeout counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      state_d        = state_q;
      boundary_c     = 1'b0;
      mem_req_c      = 1'b0;
      mem_we_c       = 1'b0;
      mem_addr_sel_c = 1'b0;
      ir_write       = 1'b0;
      pc_inc         = 1'b0;
      pc_load        = 1'b0;
      reg_write_en   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && !stop) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req_c = 1'b1;
            if (mem.mem_ack) begin
               ir_write = 1'b1;
               pc_inc   = 1'b1;
               state_d  = S_DECODE;
            end else if (to_expired_c) begin
               state_d = S_FAULT;
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            case (ir_op)
               2'b00: state_d = S_MEM;
               2'b01: state_d = S_WB;
               2'b10: begin
                  // 110 is an unconditional jump, 111 a NOP, others conditional
                  if (dec_cmp_ctrl == 3'b110)      pc_load = 1'b1;
                  else if (dec_cmp_ctrl != 3'b111) pc_load = branch_taken;
                  boundary_c = 1'b1;
               end
               default: boundary_c = 1'b1;
            endcase
         end
         S_MEM: begin
            mem_req_c      = 1'b1;
            mem_addr_sel_c = 1'b1;
            mem_we_c       = dec_mem_write;
            if (mem.mem_ack) begin
               if (dec_mem_write) boundary_c = 1'b1;
               else               state_d    = S_WB;
            end else if (to_expired_c) begin
               state_d = S_FAULT;
            end
         end
         S_WB: begin
            reg_write_en = 1'b1;
            boundary_c   = 1'b1;
         end
         S_FAULT: state_d = S_FAULT;
         default: state_d = S_FAULT;
      endcase

      // Instruction boundary: stop diverts the return to FETCH into IDLE
      if (boundary_c) state_d = stop ? S_IDLE : S_FETCH;
   end

   // Timeout counter: cleared on every state change, counts unacknowledged wait cycles
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_d != state_q)
         to_cnt_d = '0;
      else if ((state_q == S_FETCH || state_q == S_MEM) && !mem.mem_ack)
         to_cnt_d = to_cnt_q + TO_W'(1);
   end

   assign mem.mem_req      = mem_req_c;
   assign mem.mem_we       = mem_we_c;
   assign mem.mem_addr_sel = mem_addr_sel_c;

   assign busy  = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign fault = (state_q == S_FAULT);
   assign state = state_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] perf_cycles_q, perf_instrs_q;

   // Busy-cycle and retired-instruction counters, free-running with wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycles_q <= '0;
         perf_instrs_q <= '0;
      end else begin
         if (busy)       perf_cycles_q <= perf_cycles_q + 32'd1;
         if (boundary_c) perf_instrs_q <= perf_instrs_q + 32'd1;
      end
   end

   assign perf_cycles = perf_cycles_q;
   assign perf_instrs = perf_instrs_q;
`else
   assign perf_cycles = '0;
   assign perf_instrs = '0;
`endif

endmodule
